instr_sequencer: RTL and testbench
==================================

Name: instr_sequencer

Overview:
- Upstream neighbour of the instruction decoder.
- Buffers 32-bit calculator instructions arriving from the loader (keypad/UART front end) in a small FIFO.
- Issues them one at a time on a registered Instruction bus, with an instr_valid qualifier.
- Holds memory-class instructions for several cycles so the memory block can complete, and supports HALT/resume and flush.

Parameters:
- DEPTH, 8, FIFO entries; power of two, ≥2.
- MEM_LATENCY, 3, cycles a memory-class instruction stays presented; ≥1.
- CNT_W, 16, width of the issued-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- in_instr  in  32  instruction word from the loader.
- in_valid  in  1  in_instr valid.
- in_ready  out  1  FIFO can accept; push = in_valid && in_ready.
- run  in  1  level; issue allowed while high.
- resume  in  1  pulse; leaves HALTED.
- flush  in  1  pulse; discards all buffered and in-flight instructions.
- Instruction  out  32  registered instruction to the decoder.
- instr_valid  out  1  Instruction is live this cycle.
- busy  out  1  state != IDLE or FIFO non-empty.
- halted  out  1  in HALTED state.
- fifo_count  out  $clog2(DEPTH)+1  current occupancy.
- issue_count  out  CNT_W  instructions issued since reset/flush; wraps.

Behaviour:
- Reset (async, rst_n low): all outputs and state are cleared.
  - Instruction=0, instr_valid=0, halted=0, busy=0, fifo_count=0, issue_count=0, state=IDLE.
  - in_ready=1 once rst_n deasserts.
  - Reset mid-hold or mid-push aborts it; FIFO contents are lost.
- Opcode is word[31:27]. Classes:
  - MEM = 10001, 10010, 10100, 11000.
  - HALT = 11111.
  - Everything else is NORMAL.
- FIFO:
  - in_ready = (fifo_count < DEPTH), combinational from count.
  - When full, in_ready=0 even if a pop occurs the same cycle.
  - A simultaneous push and pop when not full leaves count unchanged.
  - Pointers wrap modulo DEPTH.
- FSM states: IDLE, ISSUE, MEM_HOLD, HALTED.
  - IDLE/ISSUE, pop condition: run=1 && fifo_count>0 → pop the head.
    - NORMAL: Instruction<=head, instr_valid<=1 for exactly 1 cycle, issue_count++, state=ISSUE.
    - MEM: Instruction<=head, instr_valid<=1, hold counter<=MEM_LATENCY-1, issue_count++, state=MEM_HOLD.
    - HALT: consumed; not presented; instr_valid<=0; not counted; state=HALTED, halted<=1.
  - IDLE/ISSUE, no pop: instr_valid<=0, Instruction keeps its last value, state=IDLE.
  - Back-to-back NORMAL instructions issue one per cycle, with instr_valid continuously high.
  - MEM_HOLD:
    - Instruction and instr_valid are held; the counter decrements.
    - At 0, the next-cycle decision follows the IDLE rules.
    - Total presentation is MEM_LATENCY cycles.
    - Dropping run mid-hold does not abort the hold.
  - HALTED: no pops and instr_valid=0; pushes are still accepted. resume → IDLE, halted<=0. resume outside HALTED is ignored.
- Latency: a word pushed into an empty FIFO at cycle N, with run=1, is on Instruction with instr_valid=1 at cycle N+2.
- Flush (synchronous, highest priority):
  - Next cycle: FIFO empty, instr_valid=0, state=IDLE, halted=0, issue_count=0.
  - Instruction is unchanged.
  - A push in the flush cycle is dropped.
  - resume in the flush cycle is ignored.
- issue_count wraps from 2^CNT_W-1 to 0.

Decomposition:
- Shared package calc_pkg:
  - opcode typedef (5-bit enum): MEM_ADD=10001, MEM_SUB=10010, MEM_DISP=10100, MEM_CLR=11000, HALT=11111.
  - Function is_mem_op().
  - Field-position constants OPC_MSB=31, OPC_LSB=27.
- Sub-module sync_fifo (DEPTH, WIDTH=32): push/pop/count/full/empty.
- The sequencer FSM and counters stay in instr_sequencer.

Test Plan:
- Reset: rst_n low asynchronously mid-MEM_HOLD with 3 words queued → instr_valid=0, fifo_count=0, Instruction=0 immediately, in_ready=1 after release.
- Three NORMAL words pushed (opcode 00001, data 0x0800_0002…), run=1 → presented in order on consecutive cycles, first at push-cycle+2, issue_count=3.
- MEM_ADD word 0x8800_0000 followed by a NORMAL word, MEM_LATENCY=3 → MEM_ADD held 3 cycles with instr_valid high, NORMAL appears on cycle 4.
- Fill to DEPTH=8 with run=0 → in_ready=0 at count 8; 9th in_valid is not accepted; raise run → all 8 drain in order.
- HALT between two NORMAL words → first issued; instr_valid low and halted=1 with the second still queued; resume pulse → second issued 1 cycle later.
- Flush pulse while 5 queued, mid-MEM_HOLD, with a concurrent push → next cycle fifo_count=0, instr_valid=0, issue_count=0, pushed word absent.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared calculator definitions: opcode field, opcode classes
// and the sequencer state encoding.
package calc_pkg;

    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 27;

    typedef enum logic [4:0] {
        MEM_ADD  = 5'b10001,
        MEM_SUB  = 5'b10010,
        MEM_DISP = 5'b10100,
        MEM_CLR  = 5'b11000,
        HALT     = 5'b11111
    } opcode_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_MEM_HOLD,
        S_HALTED
    } seq_state_e;

    function automatic logic [4:0] opcode_of(input logic [31:0] word);
        return word[OPC_MSB:OPC_LSB];
    endfunction

    function automatic logic is_mem_op(input logic [4:0] opc);
        case (opc)
            MEM_ADD, MEM_SUB, MEM_DISP, MEM_CLR: return 1'b1;
            default:                             return 1'b0;
        endcase
    endfunction

    function automatic logic is_halt_op(input logic [4:0] opc);
        return opc == HALT;
    endfunction

endpackage

// File: rtl/instr_sequencer_sync_fifo.sv
// Small synchronous FIFO with a combinational head read.
// Clear discards contents and wins over push/pop.
module sync_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 32
)(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push && !full && !clear;
    assign do_pop  = pop && !empty && !clear;
    assign dout    = mem[rd_ptr];

    // Storage array; contents are only meaningful between the pointers.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap modulo DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/instr_sequencer.sv
// Instruction sequencer: buffers loader words and issues them to the
// decoder, stretching memory-class words and honouring HALT/flush.
module instr_sequencer
    import calc_pkg::*;
#(
    parameter int DEPTH       = 8,
    parameter int MEM_LATENCY = 3,
    parameter int CNT_W       = 16
)(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [31:0]              in_instr,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     run,
    input  logic                     resume,
    input  logic                     flush,
    output logic [31:0]              Instruction,
    output logic                     instr_valid,
    output logic                     busy,
    output logic                     halted,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic [CNT_W-1:0]         issue_count
);

    localparam int HW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam logic [HW-1:0] HOLD_INIT = HW'(MEM_LATENCY - 1);

    seq_state_e      state;
    seq_state_e      state_d;
    logic [HW-1:0]   hold_q;
    logic [HW-1:0]   hold_d;
    logic [31:0]     instr_d;
    logic            valid_d;
    logic [CNT_W-1:0] cnt_d;

    logic [31:0]     head;
    logic            fifo_full;
    logic            fifo_empty;
    logic            push;
    logic            pop;
    logic            can_pick;
    logic [4:0]      head_opc;
    logic            head_mem;
    logic            head_halt;

    assign in_ready  = !fifo_full;
    assign push      = in_valid && in_ready && !flush;
    assign head_opc  = opcode_of(head);
    assign head_mem  = is_mem_op(head_opc);
    assign head_halt = is_halt_op(head_opc);
    assign halted    = (state == S_HALTED);
    assign busy      = (state != S_IDLE) || !fifo_empty;

    // A new word may be taken when idle, after a normal issue, or on
    // the last cycle of a memory hold.
    assign can_pick = (state == S_IDLE) || (state == S_ISSUE) ||
                      ((state == S_MEM_HOLD) && (hold_q == '0));
    assign pop = !flush && can_pick && run && !fifo_empty;

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (flush),
        .push  (push),
        .din   (in_instr),
        .pop   (pop),
        .dout  (head),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // State and issue datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            hold_q      <= '0;
            Instruction <= '0;
            instr_valid <= 1'b0;
            issue_count <= '0;
        end else begin
            state       <= state_d;
            hold_q      <= hold_d;
            Instruction <= instr_d;
            instr_valid <= valid_d;
            issue_count <= cnt_d;
        end
    end

    // Next-state selection; flush always returns to IDLE.
    always_comb begin
        state_d = state;
        if (flush) begin
            state_d = S_IDLE;
        end else if (pop) begin
            unique case (1'b1)
                head_halt: state_d = S_HALTED;
                head_mem:  state_d = S_MEM_HOLD;
                default:   state_d = S_ISSUE;
            endcase
        end else begin
            case (state)
                S_MEM_HOLD: state_d = (hold_q != '0) ? S_MEM_HOLD : S_IDLE;
                S_HALTED:   state_d = resume ? S_IDLE : S_HALTED;
                default:    state_d = S_IDLE;
            endcase
        end
    end

    // Next values of the presented word, qualifier, hold and counter.
    always_comb begin
        instr_d = Instruction;
        valid_d = instr_valid;
        hold_d  = hold_q;
        cnt_d   = issue_count;
        if (flush) begin
            valid_d = 1'b0;
            hold_d  = '0;
            cnt_d   = '0;
        end else if (pop) begin
            hold_d = '0;
            if (head_halt) begin
                valid_d = 1'b0;
            end else begin
                instr_d = head;
                valid_d = 1'b1;
                cnt_d   = issue_count + 1'b1;
                if (head_mem) begin
                    hold_d = HOLD_INIT;
                end
            end
        end else if ((state == S_MEM_HOLD) && (hold_q != '0)) begin
            hold_d = hold_q - 1'b1;
        end else begin
            valid_d = 1'b0;
            hold_d  = '0;
        end
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: directed scenarios followed
// by random traffic, all compared against a queue-based reference.
module tb_instr_sequencer;

    localparam int DEPTH = 8;
    localparam int LAT   = 3;
    localparam int CW    = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] in_instr;
    logic        in_valid;
    logic        in_ready;
    logic        run;
    logic        resume;
    logic        flush;
    logic [31:0] Instruction;
    logic        instr_valid;
    logic        busy;
    logic        halted;
    logic [3:0]  fifo_count;
    logic [CW-1:0] issue_count;

    int checks   = 0;
    int failures = 0;

    logic [31:0] q[$];
    logic [31:0] m_instr;
    bit          m_valid;
    int          m_rem;
    bit          m_halt;
    int          m_cnt;

    instr_sequencer #(
        .DEPTH       (DEPTH),
        .MEM_LATENCY (LAT),
        .CNT_W       (CW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_instr    (in_instr),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .run         (run),
        .resume      (resume),
        .flush       (flush),
        .Instruction (Instruction),
        .instr_valid (instr_valid),
        .busy        (busy),
        .halted      (halted),
        .fifo_count  (fifo_count),
        .issue_count (issue_count)
    );

    always #5 clk = ~clk;

    function automatic bit is_mem(input logic [31:0] w);
        logic [4:0] opc;
        opc = w[31:27];
        return (opc == 5'b10001) || (opc == 5'b10010) ||
               (opc == 5'b10100) || (opc == 5'b11000);
    endfunction

    function automatic logic [31:0] rand_word();
        int r;
        logic [4:0] opc;
        r = $urandom_range(0, 9);
        if (r < 5) begin
            opc = 5'($urandom_range(0, 15));
        end else if (r < 9) begin
            case ($urandom_range(0, 3))
                0:       opc = 5'b10001;
                1:       opc = 5'b10010;
                2:       opc = 5'b10100;
                default: opc = 5'b11000;
            endcase
        end else begin
            opc = 5'b11111;
        end
        return {opc, 27'($urandom)};
    endfunction

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_instr = '0;
        m_valid = 0;
        m_rem   = 0;
        m_halt  = 0;
        m_cnt   = 0;
    endtask

    // One clock of the reference: each presented word owns the bus for
    // a number of cycles; a new word is taken only when that runs out.
    task automatic model_step();
        bit acc;
        logic [31:0] w;
        if (flush) begin
            q.delete();
            m_valid = 0;
            m_rem   = 0;
            m_halt  = 0;
            m_cnt   = 0;
        end else begin
            acc = in_valid && (q.size() < DEPTH);
            if (m_halt) begin
                m_valid = 0;
                if (resume) m_halt = 0;
            end else if (m_rem > 1) begin
                m_rem--;
            end else if (run && q.size() > 0) begin
                w = q.pop_front();
                if (w[31:27] == 5'b11111) begin
                    m_valid = 0;
                    m_rem   = 0;
                    m_halt  = 1;
                end else begin
                    m_instr = w;
                    m_valid = 1;
                    m_rem   = is_mem(w) ? LAT : 1;
                    m_cnt   = (m_cnt + 1) % (1 << CW);
                end
            end else begin
                m_valid = 0;
                m_rem   = 0;
            end
            if (acc) q.push_back(in_instr);
        end
    endtask

    task automatic compare();
        check("instr",       Instruction, m_instr);
        check("instr_valid", 32'(instr_valid), 32'(m_valid));
        check("fifo_count",  32'(fifo_count), q.size());
        check("in_ready",    32'(in_ready), 32'(q.size() < DEPTH));
        check("halted",      32'(halted), 32'(m_halt));
        check("busy",        32'(busy),
              32'(m_valid || m_halt || (q.size() > 0)));
        check("issue_count", 32'(issue_count), m_cnt);
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        compare();
        resume = 0;
        flush  = 0;
    endtask

    task automatic push_tick(input logic [31:0] w);
        in_valid = 1;
        in_instr = w;
        tick();
        in_valid = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        rst_n    = 0;
        in_instr = '0;
        in_valid = 0;
        run      = 0;
        resume   = 0;
        flush    = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1;
        #1;
        compare();
        idle(2);

        // Three NORMAL words, first shown two cycles after its push.
        run = 1;
        push_tick(32'h0800_0002);
        push_tick(32'h0800_0003);
        check("lat_first", Instruction, 32'h0800_0002);
        push_tick(32'h0800_0004);
        check("b2b_second", Instruction, 32'h0800_0003);
        tick();
        check("b2b_third", Instruction, 32'h0800_0004);
        check("three_count", 32'(issue_count), 32'd3);
        idle(3);

        // MEM_ADD held three cycles, NORMAL follows on the fourth.
        push_tick(32'h8800_0000);
        push_tick(32'h0800_0005);
        idle(2);
        check("mem_hold_last", Instruction, 32'h8800_0000);
        check("mem_hold_valid", 32'(instr_valid), 32'd1);
        tick();
        check("after_mem", Instruction, 32'h0800_0005);
        idle(3);

        // Fill to DEPTH with run low; ninth word refused; then drain.
        run = 0;
        for (int i = 0; i < DEPTH; i++) push_tick(32'h0800_0010 + i);
        check("full_ready", 32'(in_ready), 32'd0);
        push_tick(32'h0800_00FF);
        check("full_count", 32'(fifo_count), 32'd8);
        run = 1;
        idle(DEPTH + 3);

        // HALT between two NORMAL words, then resume.
        push_tick(32'h0800_0020);
        push_tick(32'hF800_0000);
        push_tick(32'h0800_0021);
        tick();
        check("halt_flag", 32'(halted), 32'd1);
        check("halt_queued", 32'(fifo_count), 32'd1);
        check("halt_valid", 32'(instr_valid), 32'd0);
        resume = 1;
        tick();
        tick();
        check("resume_issue", Instruction, 32'h0800_0021);
        idle(3);

        // Flush mid-hold with five queued and a concurrent push.
        run = 0;
        push_tick(32'h9000_0001);
        for (int i = 0; i < 5; i++) push_tick(32'h0800_0030 + i);
        run = 1;
        tick();
        check("flush_pre_hold", 32'(instr_valid), 32'd1);
        in_valid = 1;
        in_instr = 32'h0800_0077;
        flush    = 1;
        resume   = 1;
        tick();
        in_valid = 0;
        check("flush_count", 32'(fifo_count), 32'd0);
        check("flush_valid", 32'(instr_valid), 32'd0);
        check("flush_issue", 32'(issue_count), 32'd0);
        check("flush_instr", Instruction, 32'h9000_0001);
        idle(3);

        // Asynchronous reset mid-hold with three words queued.
        run = 0;
        push_tick(32'hA000_0002);
        for (int i = 0; i < 3; i++) push_tick(32'h0800_0040 + i);
        run = 1;
        tick();
        #2;
        rst_n = 0;
        #1;
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_count", 32'(fifo_count), 32'd0);
        check("rst_instr", Instruction, 32'd0);
        check("rst_issue", 32'(issue_count), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        model_reset();
        #1;
        rst_n = 1;
        #1;
        check("rst_ready", 32'(in_ready), 32'd1);
        idle(2);

        // Random traffic against the reference.
        for (int c = 0; c < 3000; c++) begin
            in_valid = ($urandom_range(0, 9) < 6);
            in_instr = rand_word();
            run      = ($urandom_range(0, 9) < 8);
            resume   = ($urandom_range(0, 9) == 0);
            flush    = ($urandom_range(0, 49) == 0);
            tick();
        end
        in_valid = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
